// File: rtl/mem_tag_responder.sv
// Tagged fixed-latency memory responder: same-cycle accept/reject against a
// 15-entry tag pool, with an in-order MEM_LATENCY-deep completion pipeline.
module mem_tag_responder #(
   parameter int MEM_LATENCY = 4,
   parameter int MEM_WORDS   = 8192
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  proc2mem_command,
   input  logic [63:0] proc2mem_addr,
   input  logic [63:0] proc2mem_data,
   output logic [3:0]  mem2proc_response,
   output logic [63:0] mem2proc_data,
   output logic [3:0]  mem2proc_tag
);

   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2,
      BUS_RSVD  = 2'd3
   } bus_command_e;

   typedef struct packed {
      logic        valid;
      logic [3:0]  tag;
      logic [63:0] data;
      logic        is_store;
   } stage_t;

   localparam int          IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [63:0] ADDR_LIMIT = 64'(MEM_WORDS) << 3;

   bus_command_e     cmd;
   logic             is_load;
   logic             is_store;
   logic             req_ok;
   logic [3:0]       alloc_tag;
   logic [IDX_W-1:0] word_idx;
   logic [15:1]      free_q;
   logic [15:1]      free_d;
   stage_t           stage0_d;
   stage_t           done;
   stage_t           stage_q [MEM_LATENCY];
   logic [63:0]      mem_q   [MEM_WORDS];

   assign cmd      = bus_command_e'(proc2mem_command);
   assign is_load  = (cmd == BUS_LOAD);
   assign is_store = (cmd == BUS_STORE);
   assign word_idx = proc2mem_addr[3 +: IDX_W];
   assign done     = stage_q[MEM_LATENCY-1];

   // Lowest-numbered free tag wins; 0 means the pool is exhausted.
   always_comb begin
      // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
      alloc_tag = 4'd0;
      for (int t = 15; t >= 1; t--) begin
         if (free_q[t]) alloc_tag = 4'(t);
      end
   end

   // Gating with reset keeps the response at 0 for as long as reset is held.
   assign req_ok = reset
                   && (is_load || is_store)
                   && (proc2mem_addr[2:0] == 3'b000)
                   && (proc2mem_addr < ADDR_LIMIT)
                   && (alloc_tag != 4'd0);

   assign mem2proc_response = req_ok ? alloc_tag : 4'd0;

   // The completing tag is freed at the end of its presentation cycle, so it is
   // never the tag being allocated in that same cycle.
   always_comb begin
      free_d = free_q;
      for (int t = 1; t <= 15; t++) begin
         if (req_ok && (alloc_tag == 4'(t)))    free_d[t] = 1'b0;
         if (done.valid && (done.tag == 4'(t))) free_d[t] = 1'b1;
      end
   end

   // Loads snapshot the array word at acceptance; stores travel with data 0.
   always_comb begin
      stage0_d = '0;
      if (req_ok) begin
         stage0_d.valid    = 1'b1;
         stage0_d.tag      = alloc_tag;
         stage0_d.is_store = is_store;
         stage0_d.data     = is_store ? 64'd0 : mem_q[word_idx];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         free_q <= '1;
         for (int i = 0; i < MEM_LATENCY; i++) stage_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments so every stage samples its neighbour's old value.
         free_q     <= free_d;
         stage_q[0] <= stage0_d;
         for (int i = 1; i < MEM_LATENCY; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   // NOTE: the backing array has no reset; its contents must survive a reset pulse.
   always_ff @(posedge clock) begin
      if (req_ok && is_store) mem_q[word_idx] <= proc2mem_data;
   end

   assign mem2proc_tag  = done.valid ? done.tag : 4'd0;
   assign mem2proc_data = (done.valid && !done.is_store) ? done.data : 64'd0;

endmodule
